// File: rtl/rtlramrdarb4x.sv
// rtlramrdarb4x -- four-requester read arbiter in front of a shared RAM-config macro.
//
// Each cycle one of four level requests is granted, either round-robin from
// ptr or by fixed priority (req0 highest). A grant drives eng_re/eng_ra to the
// macro and pulses the matching ack bit. The macro returns data two clocks
// later. A 3-stage tag pipeline steers that data back as a one-cycle rdvld
// pulse at grant+3. While the CPU has a read pending on the macro, a burst
// counter forces one idle slot after MAXBURST consecutive engine reads.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   arbena            arbiter enable (also driven out as active)
//   cfgfixpri         1 = fixed priority, 0 = round-robin
//   req[3:0]          per-requester level request
//   reqa0..reqa3      per-requester read address
//   ack[3:0]          one-hot grant pulse, same cycle as eng_re
//   rdvld[3:0]        one-hot read-data valid
//   rddat             returned read data, held between pulses
//   cpupend           CPU read pending on the macro
//   eng_re, eng_ra    read enable / address to the macro
//   eng_rdd           macro read data, valid 2 clocks after eng_re
//   active            macro active qualifier
module rtlramrdarb4x #(
  parameter int ADDRBIT  = 5,
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arbena,
  input  logic               cfgfixpri,
  input  logic [3:0]         req,
  input  logic [ADDRBIT-1:0] reqa0,
  input  logic [ADDRBIT-1:0] reqa1,
  input  logic [ADDRBIT-1:0] reqa2,
  input  logic [ADDRBIT-1:0] reqa3,
  output logic [3:0]         ack,
  output logic [3:0]         rdvld,
  output logic [WIDTH-1:0]   rddat,
  input  logic               cpupend,
  output logic               eng_re,
  output logic [ADDRBIT-1:0] eng_ra,
  input  logic [WIDTH-1:0]   eng_rdd,
  output logic               active
);

  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       burst_q, burst_d;
  logic             vld_p0_q, vld_p1_q;
  logic [1:0]       idx_p0_q, idx_p1_q;
  logic [3:0]       rdvld_p2_q;
  logic [WIDTH-1:0] rddat_p2_q;

  logic [1:0]       base;
  logic [1:0]       cand;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic             supp;
  logic             gnt;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Winner search: start at ptr (or 0 in fixed-priority mode), first requester wins.
  always_comb begin
    base    = cfgfixpri ? 2'd0 : ptr_q;
    cand    = 2'd0;
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Idle slot for the CPU once MAXBURST engine reads have gone back to back.
  // Grants are also held off during reset so no ack is issued whose data the
  // cleared pipeline would then drop.
  assign supp = cpupend && (burst_q == 4'(MAXBURST));
  assign gnt  = win_vld && arbena && !supp && !rst;

  always_comb begin
    ack    = gnt ? onehot4(win_idx) : 4'b0000;
    eng_re = gnt;
    eng_ra = '0;
    if (gnt) begin
      case (win_idx)
        2'd0:    eng_ra = reqa0;
        2'd1:    eng_ra = reqa1;
        2'd2:    eng_ra = reqa2;
        default: eng_ra = reqa3;
      endcase
    end
  end

  assign ptr_d   = gnt ? win_idx + 2'd1 : ptr_q;
  assign burst_d = eng_re ? sat_inc4(burst_q) : 4'd0;
  assign active  = arbena;
  assign rdvld   = rdvld_p2_q;
  assign rddat   = rddat_p2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 2'd0;
      burst_q    <= 4'd0;
      vld_p0_q   <= 1'b0;
      idx_p0_q   <= 2'd0;
      vld_p1_q   <= 1'b0;
      idx_p1_q   <= 2'd0;
      rdvld_p2_q <= 4'b0000;
      rddat_p2_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      // Stage 0: tag of this cycle's grant
      vld_p0_q   <= gnt;
      idx_p0_q   <= win_idx;
      // Stage 1: macro data for this tag is on eng_rdd during the next cycle
      vld_p1_q   <= vld_p0_q;
      idx_p1_q   <= idx_p0_q;
      // Stage 2: capture macro data and present it with its valid
      rdvld_p2_q <= vld_p1_q ? onehot4(idx_p1_q) : 4'b0000;
      if (vld_p1_q) rddat_p2_q <= eng_rdd;
    end
  end

endmodule

// File: tb/tb_rtlramrdarb4x.sv
module tb_rtlramrdarb4x;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arbena = 1'b0;
  logic        cfgfixpri = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [4:0]  reqa0 = 5'h03;
  logic [4:0]  reqa1 = 5'h0A;
  logic [4:0]  reqa2 = 5'h1F;
  logic [4:0]  reqa3 = 5'h11;
  logic [3:0]  ack;
  logic [3:0]  rdvld;
  logic [31:0] rddat;
  logic        cpupend = 1'b0;
  logic        eng_re;
  logic [4:0]  eng_ra;
  logic [31:0] eng_rdd;
  logic        active;

  rtlramrdarb4x #(.ADDRBIT(5), .WIDTH(32), .MAXBURST(8)) dut (
    .clk(clk), .rst(rst), .arbena(arbena), .cfgfixpri(cfgfixpri), .req(req),
    .reqa0(reqa0), .reqa1(reqa1), .reqa2(reqa2), .reqa3(reqa3),
    .ack(ack), .rdvld(rdvld), .rddat(rddat), .cpupend(cpupend),
    .eng_re(eng_re), .eng_ra(eng_ra), .eng_rdd(eng_rdd), .active(active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: data = A5A5_0000 | address, valid two clocks after eng_re.
  logic [31:0] m1 = 32'h0, m2 = 32'h0;
  always @(posedge clk) begin
    m1 <= eng_re ? (32'hA5A5_0000 | {27'd0, eng_ra}) : 32'hDEAD_BEEF;
    m2 <= m1;
  end
  assign eng_rdd = m2;

  typedef struct {
    int          at;
    logic [3:0]  vld;
    logic [31:0] dat;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] addr_of(input logic [3:0] oh);
    case (oh)
      4'b0001: return reqa0;
      4'b0010: return reqa1;
      4'b0100: return reqa2;
      4'b1000: return reqa3;
      default: return 5'h00;
    endcase
  endfunction

  // One cycle: check grant outputs against the hand-computed ack, queue the
  // expected return, then advance to just after the next rising edge.
  task automatic tick(input logic [3:0] exp_ack);
    exp_t e;
    @(negedge clk);
    chk("ack", {60'd0, ack}, {60'd0, exp_ack});
    chk("eng_re", {63'd0, eng_re}, {63'd0, |exp_ack});
    chk("eng_ra", {59'd0, eng_ra}, {59'd0, addr_of(exp_ack)});
    if (exp_ack != 4'b0000) begin
      e.at  = cyc + 3;
      e.vld = exp_ack;
      e.dat = 32'hA5A5_0000 | {27'd0, addr_of(exp_ack)};
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rdvld pulse must match the oldest queued grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdvld != 4'b0000) begin
      if (q.size() == 0) begin
        chk("rdvld_unexpected", {60'd0, rdvld}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("rdvld_cycle", 64'(cyc), 64'(e.at));
        chk("rdvld", {60'd0, rdvld}, {60'd0, e.vld});
        chk("rddat", {32'd0, rddat}, {32'd0, e.dat});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", tests);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdvld", {60'd0, rdvld}, 64'd0);
    chk("rst_rddat", {32'd0, rddat}, 64'd0);
    chk("rst_ack", {60'd0, ack}, 64'd0);
    chk("rst_eng_re", {63'd0, eng_re}, 64'd0);
    chk("active", {63'd0, active}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin, all requesting: 0,1,2,3 then wrap to 0
    arbena = 1'b1; cfgfixpri = 1'b0; req = 4'b1111;
    #1 chk("active_on", {63'd0, active}, 64'd1);
    tick(4'b0001); tick(4'b0010); tick(4'b0100); tick(4'b1000); tick(4'b0001);
    req = 4'b0000;
    repeat (4) tick(4'b0000);

    // Fixed priority: req0 always wins (ptr is now 1 and must be ignored)
    cfgfixpri = 1'b1; req = 4'b1111;
    repeat (5) tick(4'b0001);
    req = 4'b0000;
    repeat (4) tick(4'b0000);

    // CPU pending: 8 grants then one idle slot, twice
    cfgfixpri = 1'b0; cpupend = 1'b1; req = 4'b0001;
    for (int i = 0; i < 18; i++) tick((i % 9 == 8) ? 4'b0000 : 4'b0001);
    req = 4'b0000; cpupend = 1'b0;
    repeat (4) tick(4'b0000);

    // Single req2 at top address; req dropped in the ack cycle; rddat holds
    req = 4'b0100;
    tick(4'b0100);
    req = 4'b0000;
    repeat (4) tick(4'b0000);
    chk("rddat_hold", {32'd0, rddat}, {32'd0, 32'hA5A5_001F});
    chk("rdvld_idle", {60'd0, rdvld}, 64'd0);

    // Continuous grants, reset mid-stream (ptr is 3 here)
    req = 4'b1111;
    tick(4'b1000); tick(4'b0001); tick(4'b0010); tick(4'b0100); tick(4'b1000);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdvld", {60'd0, rdvld}, 64'd0);
    chk("mid_rst_rddat", {32'd0, rddat}, 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4'b0001); tick(4'b0010);
    req = 4'b0000;
    repeat (4) tick(4'b0000);
    chk("drain_after_rst", 64'(q.size()), 64'd0);

    // arbena drops after two grants; both reads still return (ptr is 2 here)
    req = 4'b1111;
    tick(4'b0100); tick(4'b1000);
    arbena = 1'b0;
    repeat (5) tick(4'b0000);
    chk("drain_arbena_off", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
